bus_master_lsu: RTL and testbench
=================================

// Module: bus_master_lsu
// PURPOSE
//   Initiator end of the shared data bus (data_bus_addr/data/mode) that memory-mapped responders serve.
//   Accepts load/store requests from the core via valid/ready and turns them into word-aligned bus cycles.
//   Handles byte/half/word sizes, little-endian lane select, sign extension and misalignment errors.
//   Sits between the core's memory stage and the bus; sole driver of addr/mode.
// PARAMETERS
//   WAIT_STATES  0  extra cycles each bus phase is held beyond the first (responders have no ready line)
// PORTS
//   clk            in     1   system clock
//   reset          in     1   synchronous, active-high reset
//   req_valid      in     1   request present
//   req_ready      out    1   block can accept request (high only in IDLE)
//   req_store      in     1   1 = store, 0 = load
//   req_size       in     2   00 byte, 01 half, 10 word, 11 reserved (-> error)
//   req_unsigned   in     1   load: zero-extend instead of sign-extend
//   req_addr       in     32  byte address
//   req_wdata      in     32  store data, right-aligned
//   resp_valid     out    1   response present
//   resp_ready     in     1   core accepts response
//   resp_rdata     out    32  load result, extended; 0 for stores/errors
//   resp_err       out    1   misaligned, reserved size, or sub-word store without RMW
//   data_bus_addr  out    32  {addr[31:2],2'b00} during a phase, else 0
//   data_bus_mode  out    2   00 idle, 01 read, 10 write
//   data_bus_data  inout  32  driven only while mode==10, else 32'bz
// BEHAVIOUR
//   - Reset: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mode=00, addr=0, data z.
//   - States: IDLE, READ, WRITE, RESP. All request fields latched on req_valid&&req_ready.
//   - IDLE: misaligned (half addr[0]!=0; word addr[1:0]!=0) or size 11 -> RESP err=1, no bus cycle.
//     Load -> READ. Word store -> WRITE. Sub-word store -> READ then WRITE (RMW).
//   - READ: mode=01 for WAIT_STATES+1 cycles; bus data sampled at the clock edge ending the last cycle.
//     Load: lane=addr[1:0] (byte) / addr[1] (half), extend per req_unsigned -> RESP.
//     RMW: merge wdata low byte/half into sampled word at lane -> WRITE.
//   - WRITE: mode=10, data driven for WAIT_STATES+1 cycles -> RESP (rdata=0, err=0).
//   - RESP: resp_valid held, outputs stable until resp_ready; that edge -> IDLE. No new req accepted the same cycle.
//   - Phase counter width max(1,$clog2(WAIT_STATES+1)); reloads to 0 on every phase entry.
//   - Minimum latency (WAIT_STATES=0): accept->resp_valid load 2, word store 2, RMW store 3, error 1 cycles.
//   - Reset mid-phase: bus released same edge (mode 00, data z), pending request dropped, no response.
//   - Read-side wiring: bus data never sampled outside READ; z/X outside READ has no effect.
// CONFIGURATION
//   LSU_RMW_EN defined: sub-word stores use READ+WRITE merge as above.
//   LSU_RMW_EN undefined: sub-word stores -> RESP with err=1, no bus cycle; READ never entered for stores.
// STRUCTURE
//   Package lsu_pkg: size codes SIZE_B/H/W, bus mode codes BUS_IDLE/BUS_READ/BUS_WRITE, state enum.
//   Sub-module lsu_lane_align (combinational): load extract+extend and store merge by lane/size.
// TESTING
//   LW 0x4010, responder returns 0x0000_1234 in read cycle -> resp_rdata 0x0000_1234, err 0, mode 01 for 1 cycle.
//   LB 0x4013 signed, bus word 0x80FF_0000 -> rdata 0xFFFF_FF80; same LBU -> 0x0000_0080.
//   SB 0x2001 wdata 0xAB, memory word 0x1122_3344, RMW on -> write 0x1122_AB44; RMW off -> err 1, mode stays 00.
//   LH 0x2001 -> err 1 after 1 cycle, no bus activity; LW 0x2002 -> err 1.
//   WAIT_STATES=2, SW 0x3000 0xDEAD_BEEF -> mode 10 and data driven exactly 3 cycles, then z.
//   Reset asserted mid-READ, resp_ready held low -> next cycle mode 00, resp_valid 0, req_ready 1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the bus-master load/store unit: transfer size codes,
// bus mode codes, controller state encoding and request legality helper.
package lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_R = 2'b11;

    localparam logic [1:0] BUS_IDLE  = 2'b00;
    localparam logic [1:0] BUS_READ  = 2'b01;
    localparam logic [1:0] BUS_WRITE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } lsu_state_e;

    // A request is rejected outright when its size code is reserved or the
    // address is not naturally aligned for the requested size.
    function automatic logic req_fault(input logic [1:0] size, input logic [1:0] lo);
        logic f;
        case (size)
            SIZE_B:  f = 1'b0;
            SIZE_H:  f = lo[0];
            SIZE_W:  f = (lo != 2'b00);
            default: f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for the load/store unit: extracts and extends a
// byte/half from a bus word for loads, and merges store data into a bus word
// at the addressed lane for read-modify-write stores. Little-endian lanes.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        is_unsigned,
    input  logic [31:0] word,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed lane, extend it for loads and splice store data in.
    always_comb begin
        byte_s    = word[{lane, 3'b000} +: 8];
        half_s    = lane[1] ? word[31:16] : word[15:0];
        load_data = word;
        merged    = word;
        case (size)
            SIZE_B: begin
                if (is_unsigned) begin
                    load_data = {24'h00_0000, byte_s};
                end else begin
                    load_data = {{24{byte_s[7]}}, byte_s};
                end
                merged[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SIZE_H: begin
                if (is_unsigned) begin
                    load_data = {16'h0000, half_s};
                end else begin
                    load_data = {{16{half_s[15]}}, half_s};
                end
                if (lane[1]) begin
                    merged[31:16] = wdata;
                end else begin
                    merged[15:0] = wdata;
                end
            end
            default: begin
                load_data = word;
                merged    = word;
            end
        endcase
    end

endmodule

// File: rtl/bus_master_lsu.sv
// Initiator end of the shared data bus. Turns core load/store requests into
// word-aligned bus read/write phases, each held WAIT_STATES+1 cycles, and
// returns an extended load result or an error through a valid/ready response.
// Optional feature macro: LSU_RMW_EN -- when defined, byte/half stores are
// performed as a read phase followed by a merged write phase; when undefined
// they are answered with an error and never reach the bus.
module bus_master_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] data_bus_addr,
    output logic [1:0]  data_bus_mode,
    inout  wire  [31:0] data_bus_data
);

    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef LSU_RMW_EN
    localparam logic RMW_ON = 1'b1;
`else
    localparam logic RMW_ON = 1'b0;
`endif

    lsu_state_e  state_r, state_n;
    logic [CNT_W-1:0] cnt_r, cnt_n;
    logic [31:0] addr_r, addr_n;
    logic [1:0]  size_r, size_n;
    logic        store_r, store_n;
    logic        uns_r, uns_n;
    logic [15:0] wdata_r, wdata_n;
    logic [31:0] wr_word_r, wr_word_n;
    logic [31:0] rdata_r, rdata_n;
    logic        err_r, err_n;
    logic        resp_valid_r, resp_valid_n;
    logic        req_ready_r, req_ready_n;
    logic [1:0]  mode_r, mode_n;
    logic [31:0] bus_addr_r, bus_addr_n;
    logic [31:0] load_s;
    logic [31:0] merged_s;
    logic        reject_s;

    lsu_lane_align u_align (
        .size        (size_r),
        .lane        (addr_r[1:0]),
        .is_unsigned (uns_r),
        .word        (data_bus_data),
        .wdata       (wdata_r),
        .load_data   (load_s),
        .merged      (merged_s)
    );

    // Request rejection: bad size/alignment, or a sub-word store with no RMW path.
    always_comb begin
        reject_s = req_fault(req_size, req_addr[1:0]);
        if (req_store && (req_size != SIZE_W) && !RMW_ON) begin
            reject_s = 1'b1;
        end else begin
            reject_s = reject_s;
        end
    end

    // Next-state and next-output computation; all outputs are registered.
    always_comb begin
        state_n   = state_r;
        cnt_n     = cnt_r;
        addr_n    = addr_r;
        size_n    = size_r;
        store_n   = store_r;
        uns_n     = uns_r;
        wdata_n   = wdata_r;
        wr_word_n = wr_word_r;
        rdata_n   = rdata_r;
        err_n     = err_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid && req_ready_r) begin
                    addr_n  = req_addr;
                    size_n  = req_size;
                    store_n = req_store;
                    uns_n   = req_unsigned;
                    wdata_n = req_wdata[15:0];
                    cnt_n   = CNT_ZERO;
                    if (reject_s) begin
                        state_n = ST_RESP;
                        rdata_n = 32'h0000_0000;
                        err_n   = 1'b1;
                    end else if (!req_store) begin
                        state_n = ST_READ;
                    end else if (req_size == SIZE_W) begin
                        state_n   = ST_WRITE;
                        wr_word_n = req_wdata;
                    end else begin
                        state_n = ST_READ;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_READ: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_n = CNT_ZERO;
                    if (store_r) begin
                        // Second half of a read-modify-write store.
                        state_n   = ST_WRITE;
                        wr_word_n = merged_s;
                    end else begin
                        state_n = ST_RESP;
                        rdata_n = load_s;
                        err_n   = 1'b0;
                    end
                end else begin
                    cnt_n = cnt_r + CNT_ONE;
                end
            end
            ST_WRITE: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_n   = CNT_ZERO;
                    state_n = ST_RESP;
                    rdata_n = 32'h0000_0000;
                    err_n   = 1'b0;
                end else begin
                    cnt_n = cnt_r + CNT_ONE;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_RESP;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = CNT_ZERO;
            end
        endcase

        resp_valid_n = (state_n == ST_RESP);
        req_ready_n  = (state_n == ST_IDLE);
        case (state_n)
            ST_READ: begin
                mode_n     = BUS_READ;
                bus_addr_n = {addr_n[31:2], 2'b00};
            end
            ST_WRITE: begin
                mode_n     = BUS_WRITE;
                bus_addr_n = {addr_n[31:2], 2'b00};
            end
            default: begin
                mode_n     = BUS_IDLE;
                bus_addr_n = 32'h0000_0000;
            end
        endcase
    end

    // State and output registers; reset releases the bus on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_ZERO;
            addr_r       <= 32'h0000_0000;
            size_r       <= SIZE_B;
            store_r      <= 1'b0;
            uns_r        <= 1'b0;
            wdata_r      <= 16'h0000;
            wr_word_r    <= 32'h0000_0000;
            rdata_r      <= 32'h0000_0000;
            err_r        <= 1'b0;
            resp_valid_r <= 1'b0;
            req_ready_r  <= 1'b1;
            mode_r       <= BUS_IDLE;
            bus_addr_r   <= 32'h0000_0000;
        end else begin
            state_r      <= state_n;
            cnt_r        <= cnt_n;
            addr_r       <= addr_n;
            size_r       <= size_n;
            store_r      <= store_n;
            uns_r        <= uns_n;
            wdata_r      <= wdata_n;
            wr_word_r    <= wr_word_n;
            rdata_r      <= rdata_n;
            err_r        <= err_n;
            resp_valid_r <= resp_valid_n;
            req_ready_r  <= req_ready_n;
            mode_r       <= mode_n;
            bus_addr_r   <= bus_addr_n;
        end
    end

    assign req_ready     = req_ready_r;
    assign resp_valid    = resp_valid_r;
    assign resp_rdata    = rdata_r;
    assign resp_err      = err_r;
    assign data_bus_mode = mode_r;
    assign data_bus_addr = bus_addr_r;
    assign data_bus_data = (mode_r == BUS_WRITE) ? wr_word_r : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_bus_master_lsu.sv
// Randomized self-checking bench for bus_master_lsu. Two instances (0 and 2
// wait states) receive identical requests; each has its own bus responder
// memory. A transaction-level model predicts result, error, latency and the
// number of read/write bus cycles from the request rules.
module tb_bus_master_lsu;

`ifdef LSU_RMW_EN
    localparam bit RMW = 1'b1;
`else
    localparam bit RMW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_store, req_unsigned, resp_ready;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;

    logic        req_ready_a, resp_valid_a, resp_err_a;
    logic [31:0] resp_rdata_a, addr_a;
    logic [1:0]  mode_a;
    wire  [31:0] bus_a;
    logic        req_ready_b, resp_valid_b, resp_err_b;
    logic [31:0] resp_rdata_b, addr_b;
    logic [1:0]  mode_b;
    wire  [31:0] bus_b;

    logic [31:0] mem_a [16];
    logic [31:0] mem_b [16];
    logic [31:0] ref_mem [16];
    logic [31:0] junk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc;
    int lat [2];
    int rd  [2];
    int wr  [2];
    int bad_wd [2];
    int bad_ad [2];
    logic [31:0] exp_wword, exp_baddr;

    always #5 clk = ~clk;

    always @(posedge clk) junk <= $urandom;

    // Responders: serve reads from memory; scribble junk on an idle bus.
    assign bus_a = (mode_a == 2'b01) ? mem_a[addr_a[5:2]] : ((mode_a == 2'b00) ? junk : 32'hzzzz_zzzz);
    assign bus_b = (mode_b == 2'b01) ? mem_b[addr_b[5:2]] : ((mode_b == 2'b00) ? ~junk : 32'hzzzz_zzzz);

    bus_master_lsu #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_a),
        .req_store(req_store), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid_a),
        .resp_ready(resp_ready), .resp_rdata(resp_rdata_a), .resp_err(resp_err_a),
        .data_bus_addr(addr_a), .data_bus_mode(mode_a), .data_bus_data(bus_a)
    );

    bus_master_lsu #(.WAIT_STATES(2)) u_ws2 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_b),
        .req_store(req_store), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid_b),
        .resp_ready(resp_ready), .resp_rdata(resp_rdata_b), .resp_err(resp_err_b),
        .data_bus_addr(addr_b), .data_bus_mode(mode_b), .data_bus_data(bus_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_word(input int idx, input logic [31:0] val);
        ref_mem[idx] = val;
        mem_a[idx]   = val;
        mem_b[idx]   = val;
    endtask

    // One negedge worth of bus observation for both instances.
    task automatic sample_cycle();
        cyc++;
        if (resp_valid_a && lat[0] == 0) lat[0] = cyc;
        if (resp_valid_b && lat[1] == 0) lat[1] = cyc;
        if (mode_a == 2'b01) rd[0]++;
        if (mode_b == 2'b01) rd[1]++;
        if (mode_a == 2'b10) begin
            wr[0]++;
            if (bus_a !== exp_wword) bad_wd[0]++;
            mem_a[addr_a[5:2]] = bus_a;
        end
        if (mode_b == 2'b10) begin
            wr[1]++;
            if (bus_b !== exp_wword) bad_wd[1]++;
            mem_b[addr_b[5:2]] = bus_b;
        end
        if (mode_a == 2'b11 || (mode_a != 2'b00 && addr_a != exp_baddr) || (mode_a == 2'b00 && addr_a != 32'h0)) bad_ad[0]++;
        if (mode_b == 2'b11 || (mode_b != 2'b00 && addr_b != exp_baddr) || (mode_b == 2'b00 && addr_b != 32'h0)) bad_ad[1]++;
    endtask

    task automatic run_txn(input logic st, input logic [1:0] sz, input logic un,
                           input logic [31:0] ad, input logic [31:0] wd,
                           output logic [31:0] got_rdata, output logic got_err);
        int idx, sh, hold;
        logic fault;
        logic [31:0] w, e_rdata, nw, mask;
        int e_lat [2];
        int e_rd [2];
        int e_wr [2];
        int ws [2];
        ws[0] = 0;
        ws[1] = 2;
        idx = int'(ad[5:2]);
        w   = ref_mem[idx];
        fault = (sz == 2'd3) || (sz == 2'd1 && ad[0]) || (sz == 2'd2 && ad[1:0] != 2'b00)
                || (st && sz != 2'd2 && !RMW);
        e_rdata = 32'h0;
        nw = w;
        if (!fault && !st) begin
            if (sz == 2'd0) begin
                e_rdata = (w >> (8 * int'(ad[1:0]))) & 32'hFF;
                if (!un && e_rdata[7]) e_rdata = e_rdata | 32'hFFFF_FF00;
            end else if (sz == 2'd1) begin
                e_rdata = (w >> (16 * int'(ad[1]))) & 32'hFFFF;
                if (!un && e_rdata[15]) e_rdata = e_rdata | 32'hFFFF_0000;
            end else begin
                e_rdata = w;
            end
        end
        if (!fault && st) begin
            if (sz == 2'd2) begin
                nw = wd;
            end else begin
                sh   = (sz == 2'd0) ? 8 * int'(ad[1:0]) : 16 * int'(ad[1]);
                mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
                nw   = (w & ~mask) | ((wd << sh) & mask);
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (fault) begin
                e_lat[k] = 1; e_rd[k] = 0; e_wr[k] = 0;
            end else if (!st) begin
                e_lat[k] = ws[k] + 2; e_rd[k] = ws[k] + 1; e_wr[k] = 0;
            end else if (sz == 2'd2) begin
                e_lat[k] = ws[k] + 2; e_rd[k] = 0; e_wr[k] = ws[k] + 1;
            end else begin
                e_lat[k] = 2 * ws[k] + 3; e_rd[k] = ws[k] + 1; e_wr[k] = ws[k] + 1;
            end
        end
        exp_wword = nw;
        exp_baddr = {ad[31:2], 2'b00};

        @(negedge clk);
        check_val("req_ready_a", {31'h0, req_ready_a}, 32'h1);
        check_val("req_ready_b", {31'h0, req_ready_b}, 32'h1);
        req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = un;
        req_addr = ad; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        req_size = 2'($urandom_range(0, 3)); req_store = 1'($urandom_range(0, 1));
        cyc = 0;
        for (int k = 0; k < 2; k++) begin
            lat[k] = 0; rd[k] = 0; wr[k] = 0; bad_wd[k] = 0; bad_ad[k] = 0;
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            sample_cycle();
            if (lat[0] != 0 && lat[1] != 0) break;
        end
        check_val("lat_ws0", lat[0], e_lat[0]);
        check_val("lat_ws2", lat[1], e_lat[1]);
        check_val("rdcyc_ws0", rd[0], e_rd[0]);
        check_val("rdcyc_ws2", rd[1], e_rd[1]);
        check_val("wrcyc_ws0", wr[0], e_wr[0]);
        check_val("wrcyc_ws2", wr[1], e_wr[1]);
        check_val("wdata_ws0", bad_wd[0], 0);
        check_val("wdata_ws2", bad_wd[1], 0);
        check_val("busaddr_ws0", bad_ad[0], 0);
        check_val("busaddr_ws2", bad_ad[1], 0);
        hold = $urandom_range(0, 2);
        for (int h = 0; h < hold; h++) @(negedge clk);
        check_val("rvalid_ws0", {31'h0, resp_valid_a}, 32'h1);
        check_val("rvalid_ws2", {31'h0, resp_valid_b}, 32'h1);
        check_val("rdata_ws0", resp_rdata_a, e_rdata);
        check_val("rdata_ws2", resp_rdata_b, e_rdata);
        check_val("err_ws0", {31'h0, resp_err_a}, {31'h0, fault});
        check_val("err_ws2", {31'h0, resp_err_b}, {31'h0, fault});
        got_rdata = resp_rdata_a;
        got_err   = resp_err_a;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        check_val("drain_valid", {30'h0, resp_valid_a, resp_valid_b}, 32'h0);
        check_val("drain_ready", {30'h0, req_ready_a, req_ready_b}, 32'h3);
        check_val("drain_mode", {28'h0, mode_a, mode_b}, 32'h0);
        if (!fault && st) ref_mem[idx] = nw;
    endtask

    initial begin
        logic [31:0] rdv;
        logic        erv;
        logic [31:0] a;
        logic [1:0]  sz;
        reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
        for (int i = 0; i < 16; i++) set_word(i, $urandom);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_val("rst_ready", {30'h0, req_ready_a, req_ready_b}, 32'h3);
        check_val("rst_valid", {30'h0, resp_valid_a, resp_valid_b}, 32'h0);
        check_val("rst_rdata", resp_rdata_a | resp_rdata_b, 32'h0);
        check_val("rst_err", {30'h0, resp_err_a, resp_err_b}, 32'h0);
        check_val("rst_mode", {28'h0, mode_a, mode_b}, 32'h0);
        check_val("rst_addr", addr_a | addr_b, 32'h0);

        set_word(4, 32'h0000_1234);
        run_txn(1'b0, 2'd2, 1'b0, 32'h0000_4010, 32'h0, rdv, erv);
        check_val("lw_const", rdv, 32'h0000_1234);
        set_word(4, 32'h80FF_0000);
        run_txn(1'b0, 2'd0, 1'b0, 32'h0000_4013, 32'h0, rdv, erv);
        check_val("lb_const", rdv, 32'hFFFF_FF80);
        run_txn(1'b0, 2'd0, 1'b1, 32'h0000_4013, 32'h0, rdv, erv);
        check_val("lbu_const", rdv, 32'h0000_0080);
        set_word(0, 32'h1122_3344);
        run_txn(1'b1, 2'd0, 1'b0, 32'h0000_2001, 32'h0000_00AB, rdv, erv);
        check_val("sb_err_const", {31'h0, erv}, {31'h0, !RMW});
        check_val("sb_mem_const", mem_a[0], RMW ? 32'h1122_AB44 : 32'h1122_3344);
        run_txn(1'b0, 2'd1, 1'b0, 32'h0000_2001, 32'h0, rdv, erv);
        check_val("lh_mis_const", {31'h0, erv}, 32'h1);
        run_txn(1'b0, 2'd2, 1'b0, 32'h0000_2002, 32'h0, rdv, erv);
        check_val("lw_mis_const", {31'h0, erv}, 32'h1);
        run_txn(1'b1, 2'd2, 1'b0, 32'h0000_3000, 32'hDEAD_BEEF, rdv, erv);
        check_val("sw_wrcyc_ws2", wr[1], 3);
        check_val("sw_mem_const", mem_b[0], 32'hDEAD_BEEF);

        for (int t = 0; t < 60; t++) begin
            a  = $urandom;
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            run_txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, rdv, erv);
        end

        // Reset in the middle of a read phase drops the request silently.
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_size = 2'd2; req_addr = 32'h0000_4010;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check_val("mid_read_mode", {28'h0, mode_a, mode_b}, 32'h5);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_val("rst_mid_mode", {28'h0, mode_a, mode_b}, 32'h0);
        check_val("rst_mid_valid", {30'h0, resp_valid_a, resp_valid_b}, 32'h0);
        check_val("rst_mid_ready", {30'h0, req_ready_a, req_ready_b}, 32'h3);
        repeat (6) @(negedge clk);
        check_val("rst_mid_noresp", {30'h0, resp_valid_a, resp_valid_b}, 32'h0);
        check_val("rst_mid_idle", {28'h0, mode_a, mode_b}, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
